// File: rtl/text_line_streamer.sv
// Text line streamer: prefetches console rows from the text RAM into two ping-pong
// line buffers and streams them one cell per handshake with row/column/cursor tags.
module text_line_streamer #(
    parameter int COLUMNS = 80,
    parameter int LINES   = 30,
    parameter int CHAR_W  = 32,
    parameter int RD_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [7:0]                cursor_x,
    input  logic [7:0]                cursor_y,
    input  logic                      cursor_en,
    output logic                      ram_rden,
    output logic [7:0]                ram_addr,
    input  logic [COLUMNS*CHAR_W-1:0] ram_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHAR_W-1:0]         out_data,
    output logic [7:0]                out_row,
    output logic [7:0]                out_col,
    output logic                      out_cursor,
    output logic                      out_last,
    output logic                      out_frame_end,
    output logic                      busy
);
    localparam int         LINE_W   = COLUMNS * CHAR_W;
    localparam logic [7:0] COL_LAST = 8'(COLUMNS - 1);
    localparam logic [7:0] ROW_LAST = 8'(LINES - 1);
    localparam logic [7:0] ROW_END  = 8'(LINES);
    localparam logic [7:0] LAT_INIT = 8'(RD_LAT - 1);

    typedef enum logic {F_IDLE, F_WAIT} fetch_t;

    fetch_t            fstate, fstate_n;
    logic [7:0]        wait_cnt, wait_cnt_n;
    logic [LINE_W-1:0] line_buf0, line_buf1, next_line;
    logic [1:0]        full, full_n;
    logic              rd_sel, rd_sel_n, wr_sel, wr_sel_n;
    logic [7:0]        fetch_row, fetch_row_n, row_n, col_n;
    logic              busy_n, hs, capture;
    logic [7:0]        cur_x_l, cur_y_l, cur_x_n, cur_y_n;
    logic              cur_en_l, cur_en_n;

    function automatic logic [CHAR_W-1:0] cell_at(input logic [LINE_W-1:0] row_bits,
                                                  input logic [7:0] col);
        return row_bits[int'(col)*CHAR_W +: CHAR_W];
    endfunction

    assign out_valid = full[rd_sel];
    assign hs        = out_valid && out_ready;
    // A restart suppresses a same-cycle read so no stale row is left in flight.
    assign ram_rden  = (fstate == F_IDLE) && busy && !frame_start &&
                       (fetch_row < ROW_END) && !full[wr_sel];
    assign ram_addr  = fetch_row;

    always_comb begin
        fstate_n    = fstate;
        wait_cnt_n  = wait_cnt;
        full_n      = full;
        rd_sel_n    = rd_sel;
        wr_sel_n    = wr_sel;
        fetch_row_n = fetch_row;
        row_n       = out_row;
        col_n       = out_col;
        busy_n      = busy;
        cur_x_n     = cur_x_l;
        cur_y_n     = cur_y_l;
        cur_en_n    = cur_en_l;
        capture     = 1'b0;
        if (frame_start) begin
            fstate_n    = F_IDLE;
            wait_cnt_n  = 8'd0;
            full_n      = 2'b00;
            rd_sel_n    = 1'b0;
            wr_sel_n    = 1'b0;
            fetch_row_n = 8'd0;
            row_n       = 8'd0;
            col_n       = 8'd0;
            busy_n      = 1'b1;
            cur_x_n     = cursor_x;
            cur_y_n     = cursor_y;
            cur_en_n    = cursor_en;
        end else begin
            if (hs) begin
                if (out_col == COL_LAST) begin
                    col_n          = 8'd0;
                    row_n          = out_row + 8'd1;
                    full_n[rd_sel] = 1'b0;
                    rd_sel_n       = !rd_sel;
                    if (out_row == ROW_LAST) begin
                        busy_n = 1'b0;
                    end
                end else begin
                    col_n = out_col + 8'd1;
                end
            end
            case (fstate)
                F_IDLE: begin
                    if (ram_rden) begin
                        fstate_n   = F_WAIT;
                        wait_cnt_n = LAT_INIT;
                    end
                end
                F_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        capture        = 1'b1;
                        full_n[wr_sel] = 1'b1;
                        wr_sel_n       = !wr_sel;
                        fetch_row_n    = fetch_row + 8'd1;
                        fstate_n       = F_IDLE;
                    end else begin
                        wait_cnt_n = wait_cnt - 8'd1;
                    end
                end
                default: fstate_n = F_IDLE;
            endcase
        end
    end

    // The cell presented next cycle may come straight from a line captured this cycle.
    assign next_line = (capture && (wr_sel == rd_sel_n)) ? ram_q :
                       (rd_sel_n ? line_buf1 : line_buf0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fstate        <= F_IDLE;
            wait_cnt      <= 8'd0;
            full          <= 2'b00;
            rd_sel        <= 1'b0;
            wr_sel        <= 1'b0;
            fetch_row     <= 8'd0;
            out_row       <= 8'd0;
            out_col       <= 8'd0;
            busy          <= 1'b0;
            cur_x_l       <= 8'd0;
            cur_y_l       <= 8'd0;
            cur_en_l      <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_frame_end <= 1'b0;
            out_cursor    <= 1'b0;
        end else begin
            fstate        <= fstate_n;
            wait_cnt      <= wait_cnt_n;
            full          <= full_n;
            rd_sel        <= rd_sel_n;
            wr_sel        <= wr_sel_n;
            fetch_row     <= fetch_row_n;
            out_row       <= row_n;
            out_col       <= col_n;
            busy          <= busy_n;
            cur_x_l       <= cur_x_n;
            cur_y_l       <= cur_y_n;
            cur_en_l      <= cur_en_n;
            out_data      <= cell_at(next_line, col_n);
            out_last      <= (col_n == COL_LAST);
            out_frame_end <= (col_n == COL_LAST) && (row_n == ROW_LAST);
            out_cursor    <= cur_en_n && (row_n < ROW_END) &&
                             (row_n == cur_x_n) && (col_n == cur_y_n);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            if (wr_sel) begin
                line_buf1 <= ram_q;
            end else begin
                line_buf0 <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_text_line_streamer.sv
// Bench for text_line_streamer: latency-accurate text RAM model, a frame-order
// reference model checked every cycle, and directed scenarios with literal pins.
module tb_text_line_streamer;
    localparam int COLUMNS = 80;
    localparam int LINES   = 30;
    localparam int CHAR_W  = 32;
    localparam int RD_LAT  = 2;
    localparam int TOTAL   = COLUMNS * LINES;

    logic clk = 1'b0, rst = 1'b0, frame_start = 1'b0, cursor_en = 1'b0, out_ready = 1'b0;
    logic [7:0] cursor_x = 8'd0, cursor_y = 8'd0;
    logic ram_rden, out_valid, out_cursor, out_last, out_frame_end, busy;
    logic [7:0] ram_addr, out_row, out_col;
    logic [COLUMNS*CHAR_W-1:0] ram_q;
    logic [CHAR_W-1:0] out_data;

    int checks = 0, failures = 0, cyc = 0, fs_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_line_streamer #(.COLUMNS(COLUMNS), .LINES(LINES), .CHAR_W(CHAR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .cursor_en(cursor_en), .ram_rden(ram_rden), .ram_addr(ram_addr),
        .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_cursor(out_cursor), .out_last(out_last),
        .out_frame_end(out_frame_end), .busy(busy)
    );

    function automatic logic [CHAR_W-1:0] exp_cell(input int r, input int c);
        return {24'(r), 8'(c)};
    endfunction

    function automatic logic [COLUMNS*CHAR_W-1:0] make_line(input logic [7:0] a);
        logic [COLUMNS*CHAR_W-1:0] l;
        for (int c = 0; c < COLUMNS; c++) l[c*CHAR_W +: CHAR_W] = exp_cell(int'(a), c);
        return l;
    endfunction

    function automatic logic [63:0] pack(input logic [31:0] d, input logic [7:0] r,
                                         input logic [7:0] c, input logic l,
                                         input logic fe, input logic cu);
        return {13'd0, d, r, c, l, fe, cu};
    endfunction

    // Text RAM: data for an address read in cycle t is on ram_q only in cycle t+RD_LAT.
    logic [7:0]        pa [RD_LAT];
    logic [RD_LAT-1:0] pv = '0;
    always @(posedge clk) begin
        pa[0] <= ram_addr;
        pv[0] <= ram_rden;
        for (int i = 1; i < RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
    end
    always_comb ram_q = pv[RD_LAT-1] ? make_line(pa[RD_LAT-1]) : '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: a frame is the cells (r,c) in row-major order, each accepted once.
    int exp_idx = 0, fetch_cnt = 0, since_rd = 1000;
    logic exp_busy = 1'b0, prev_stall = 1'b0, len = 1'b0;
    logic [7:0] lx = 8'd0, ly = 8'd0;
    logic [63:0] prev_beat = '0, st_first_beat = '0;
    int st_first_rd = -1, st_first_addr = -1, st_first_valid = -1, st_last_valid = -1;
    int st_nvalid = 0, st_nacc = 0, st_nfe = 0, st_ncur = 0, st_cur_pos = -1;

    always @(negedge clk) begin
        logic [63:0] act, want;
        int r, c;
        act = pack(out_data, out_row, out_col, out_last, out_frame_end, out_cursor);
        if (!rst) begin
            check("reset_outputs", 64'({ram_rden, ram_addr, out_valid, out_data, out_row, out_col,
                                        out_cursor, out_last, out_frame_end, busy}), 64'd0);
            exp_idx = 0; fetch_cnt = 0; since_rd = 1000; exp_busy = 1'b0; prev_stall = 1'b0;
        end else begin
            check("busy", 64'(busy), 64'(exp_busy));
            if (!exp_busy) check("idle_quiet", 64'({out_valid, ram_rden}), 64'd0);
            if (prev_stall) check("stall_stable", {out_valid, act[62:0]}, {1'b1, prev_beat[62:0]});
            if (out_valid) begin
                if (exp_idx >= TOTAL) begin
                    check("extra_beat_valid", 64'(out_valid), 64'd0);
                end else begin
                    r = exp_idx / COLUMNS;
                    c = exp_idx % COLUMNS;
                    want = pack(exp_cell(r, c), 8'(r), 8'(c), c == COLUMNS - 1,
                                exp_idx == TOTAL - 1, len && int'(lx) == r && int'(ly) == c);
                    check("beat", act, want);
                end
                if (st_first_valid < 0) begin st_first_valid = cyc; st_first_beat = act; end
                st_last_valid = cyc;
                st_nvalid++;
                if (out_frame_end) st_nfe++;
                if (out_ready && !frame_start) begin
                    st_nacc++;
                    if (out_cursor) begin st_ncur++; st_cur_pos = int'(out_row) * 256 + int'(out_col); end
                end
            end
            if (ram_rden && !frame_start) begin
                check("rd_addr_in_order", 64'(ram_addr), 64'(fetch_cnt));
                if (fetch_cnt >= LINES) check("rd_beyond_frame", 64'(ram_rden), 64'd0);
                check("rd_one_in_flight", 64'(since_rd >= RD_LAT), 64'd1);
                check("rd_buffer_room", 64'((fetch_cnt - exp_idx / COLUMNS) <= 1), 64'd1);
                if (st_first_rd < 0) begin st_first_rd = cyc; st_first_addr = int'(ram_addr); end
                fetch_cnt++;
                since_rd = 0;
            end else begin
                since_rd++;
            end
            if (frame_start) begin
                exp_idx = 0; fetch_cnt = 0; since_rd = 1000; exp_busy = 1'b1; prev_stall = 1'b0;
                lx = cursor_x; ly = cursor_y; len = cursor_en;
                st_first_rd = -1; st_first_addr = -1; st_first_valid = -1; st_last_valid = -1;
                st_nvalid = 0; st_nacc = 0; st_nfe = 0; st_ncur = 0; st_cur_pos = -1;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_idx == TOTAL - 1) exp_busy = 1'b0;
                    exp_idx++;
                end
                prev_stall = out_valid && !out_ready;
                prev_beat  = act;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] x, input logic [7:0] y, input logic en);
        cursor_x = x; cursor_y = y; cursor_en = en;
        frame_start = 1'b1;
        fs_cyc = cyc;
        step();
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int ready_pct, input int move_at);
        for (int i = 0; i < 8000; i++) begin
            if (i == move_at) begin cursor_x = 8'd0; cursor_y = 8'd0; end
            out_ready = ($urandom_range(99) < ready_pct);
            step();
            if (!busy) break;
        end
        check("frame_done_in_budget", 64'(busy), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit found;
        idle(3);
        rst = 1'b1;
        idle(5);

        // Full frame with ready held high: latency and gap-free streaming.
        start_frame(8'd0, 8'd0, 1'b0);
        run_frame(100, -1);
        check("first_rd_latency", 64'(st_first_rd - fs_cyc), 64'd1);
        check("first_rd_addr", 64'(st_first_addr), 64'd0);
        check("first_valid_latency", 64'(st_first_valid - fs_cyc), 64'd4);
        check("first_beat", st_first_beat, pack(32'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        check("valid_cycles", 64'(st_nvalid), 64'(TOTAL));
        check("gap_free_span", 64'(st_last_valid - st_first_valid + 1), 64'(TOTAL));
        check("frame_end_count", 64'(st_nfe), 64'd1);
        idle(20);

        // Random backpressure.
        start_frame(8'd200, 8'd200, 1'b0);
        run_frame(60, -1);
        check("bp_accepted", 64'(st_nacc), 64'(TOTAL));
        idle(10);

        // Cursor cases: visible and moved mid-frame, disabled, row out of range.
        start_frame(8'd5, 8'd79, 1'b1);
        run_frame(80, 100);
        check("cursor_hits", 64'(st_ncur), 64'd1);
        check("cursor_pos", 64'(st_cur_pos), 64'(5 * 256 + 79));
        start_frame(8'd5, 8'd79, 1'b0);
        run_frame(80, -1);
        check("cursor_disabled_hits", 64'(st_ncur), 64'd0);
        start_frame(8'd30, 8'd0, 1'b1);
        run_frame(100, -1);
        check("cursor_oob_hits", 64'(st_ncur), 64'd0);
        idle(5);

        // Restart in the cycle after the row-7 read.
        start_frame(8'd0, 8'd0, 1'b0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ram_rden && ram_addr == 8'd7) begin found = 1'b1; break; end
            step();
        end
        check("row7_read_seen", 64'(found), 64'd1);
        step();
        start_frame(8'd0, 8'd0, 1'b0);
        run_frame(100, -1);
        check("restart_rd_latency", 64'(st_first_rd - fs_cyc), 64'd1);
        check("restart_rd_addr", 64'(st_first_addr), 64'd0);
        check("restart_valid_latency", 64'(st_first_valid - fs_cyc), 64'd4);
        check("restart_first_beat", st_first_beat, pack(32'h0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        check("restart_accepted", 64'(st_nacc), 64'(TOTAL));

        // Asynchronous reset mid-stream at row 12, col 40.
        start_frame(8'd0, 8'd0, 1'b0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (out_row == 8'd12 && out_col == 8'd40) begin found = 1'b1; break; end
            step();
        end
        check("reached_row12_col40", 64'(found), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_reset", 64'({ram_rden, ram_addr, out_valid, out_data, out_row, out_col,
                                  out_cursor, out_last, out_frame_end, busy}), 64'd0);
        out_ready = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(30);

        // Recovery frame after reset.
        start_frame(8'd29, 8'd0, 1'b1);
        run_frame(90, -1);
        check("recovery_accepted", 64'(st_nacc), 64'(TOTAL));
        check("recovery_cursor_pos", 64'(st_cur_pos), 64'(29 * 256));
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_line_streamer.md
# text_line_streamer

Display-side consumer of the text RAM that the text editing stage writes. On each frame start it reads console rows in order through the RAM's read port and ping-pongs each full line into one of two line buffers. It then streams the characters one per handshake, with row/column/cursor tags, to the glyph renderer. Prefetching the next row hides read latency, so a renderer holding ready high sees a gap-free stream.

## Interface
- `COLUMNS`, 80: characters per row (`CONSOLE_COLUMNS`).
- `LINES`, 30: rows per frame (`CONSOLE_LINES`).
- `CHAR_W`, 32: bits per character cell (`TEXT_RAM_CHAR_WIDTH`).
- `RD_LAT`, 2: text RAM read latency in cycles, ≥1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse; starts (or restarts) a frame.
- `cursor_x`, `cursor_y`  in  8 each  cursor row / column.
- `cursor_en`  in  1  cursor visible.
- `ram_rden`  out  1  read strobe, one cycle per read.
- `ram_addr`  out  8  row address, valid when `ram_rden`.
- `ram_q`  in  COLUMNS*CHAR_W  line read data.
- `out_valid`  out  1  character available.
- `out_ready`  in  1  renderer accepts.
- `out_data`  out  CHAR_W  cell {attribute, char}; column c is `ram_q[CHAR_W*c +: CHAR_W]`.
- `out_row`, `out_col`  out  8 each  position of `out_data`.
- `out_cursor`  out  1  this cell is under the visible cursor.
- `out_last`  out  1  last column of a row.
- `out_frame_end`  out  1  last cell of the frame.
- `busy`  out  1  frame in progress.

## Operation
- **Buffers:** two line buffers `buf[0..1]`, each with a full flag. Read pointer `rd_sel`, write pointer `wr_sel`.
- **Fetch FSM (F_IDLE, F_WAIT):**
  - In F_IDLE, a read issues when `busy`, `fetch_row < LINES` and `buf[wr_sel]` is not full. Issuing pulses `ram_rden` with `ram_addr = fetch_row` and enters F_WAIT with a countdown of RD_LAT.
  - At most one read is in flight.
  - In F_WAIT, at countdown 0, `ram_q` is captured into `buf[wr_sel]`. Capture sets the full flag, toggles `wr_sel`, increments `fetch_row`, and returns to F_IDLE.
- **Stream side:**
  - `out_valid` = `buf[rd_sel]` full.
  - `out_data` = the cell of `buf[rd_sel]` at `out_col`.
  - A handshake (`out_valid && out_ready`) increments `out_col`.
  - On the handshake at `out_col == COLUMNS-1`: `out_col` goes to 0, `out_row` increments, the buffer's full flag clears, and `rd_sel` toggles.
- **Tags:**
  - `out_last` = `out_col == COLUMNS-1`.
  - `out_frame_end` = `out_last && out_row == LINES-1`.
  - `out_cursor` = `cur_en_l && out_row == cur_x_l && out_col == cur_y_l`. The `_l` values are latched at `frame_start`, so a cursor move mid-frame takes effect next frame.
- **Frame end:** on the `out_frame_end` handshake, `busy` clears and the block goes idle.
- **`frame_start` (idle or mid-frame):**
  - Clears both full flags, `rd_sel`, `wr_sel`, `fetch_row`, `out_row` and `out_col`.
  - Latches the cursor values, sets `busy`, and forces the fetch FSM to F_IDLE.
  - Any in-flight read result is discarded and never written to a buffer.
  - `frame_start` has priority over a same-cycle handshake or capture.
- **Out-of-range cursor:** `cursor_x ≥ LINES` or `cursor_y ≥ COLUMNS` never matches.
- **Cell contents:** passed through unmodified; blank cells are not substituted.
- **Width rules:** row/column counters are 8 bits; COLUMNS and LINES must be ≤ 255.

## Timing
- **Reset values:**
  - `ram_rden=0`, `ram_addr=0`.
  - `out_valid=0`, `out_data=0`.
  - `out_row=0`, `out_col=0`.
  - `out_cursor=0`, `out_last=0`, `out_frame_end=0`, `busy=0`.
  - Both buffers empty; fetch FSM in F_IDLE.
- **Mid-operation reset:** returns to the reset state immediately, with no pending read honoured.
- **First read:** with `frame_start` high in cycle 0, `ram_rden` is high in cycle 1 with address 0.
- **Capture:** `ram_q` is sampled at the end of cycle 1+RD_LAT. For RD_LAT=2 that is the end of cycle 3, and `out_valid` is high from cycle 4.
- **Row 1:** read issues in the cycle after row 0's capture (cycle 4); captured end of cycle 6.
- **Refill:** a buffer freed by a last-column handshake at the end of cycle T is re-requested in cycle T+1.
- **Back-to-back streaming:** with `out_ready` held high, consecutive rows stream without bubbles whenever COLUMNS ≥ RD_LAT+2.
- **Full frame, ready always high:** COLUMNS*LINES consecutive valid cycles. `out_frame_end` is high on exactly one of them.
- **Output registers:** `out_data`, `out_row`, `out_col`, `out_cursor`, `out_last` and `out_frame_end` are driven from registers. They stay stable while `out_valid && !out_ready`.
- **`busy`:** rises the cycle after `frame_start`; falls the cycle after the final handshake.

## Test plan
- **First-row latency and contents.** Reset, then `frame_start`, `out_ready`=1, RAM model RD_LAT=2 with row r, column c = {24'(r), 8'(c)}.
  - First `ram_rden` in cycle 1 with addr 0.
  - First `out_valid` in cycle 4 with data 0x00000000, row 0, col 0.
  - 2400 consecutive beats for a 30-row frame.
  - `out_last` on every col 79; `out_frame_end` only at (29,79).
- **Backpressure.** Toggle `out_ready` pseudo-randomly.
  - The accepted sequence is identical to the no-backpressure run.
  - Outputs stay stable during stalls.
  - No row fetched twice; never more than one read in flight.
- **Cursor.** Set cursor (5,79) with `cursor_en`=1 at `frame_start`, then move it to (0,0) mid-frame.
  - `out_cursor` high only at (5,79).
  - Repeat with `cursor_en`=0: never high.
  - Repeat with cursor (30,0): never high.
- **Restart mid-read.** Assert `frame_start` in the cycle after a `ram_rden` for row 7.
  - The row-7 return is discarded.
  - Next `ram_rden` has addr 0.
  - First beat is row 0, col 0 in cycle 4 after the restart.
- **Reset mid-stream.** Drop `rst` at row 12, col 40.
  - All outputs go to reset values asynchronously.
  - After release, nothing is issued until `frame_start`.
- **Frame end.** After `out_frame_end` is accepted:
  - `busy` falls next cycle.
  - No further `ram_rden` and `out_valid`=0 until the next `frame_start`.
